// File: rtl/sseg_pkg.sv
// sseg_pkg: segment constants, polarity helper and index width for sseg_scan_driver.
package sseg_pkg;
  localparam int N_DIGITS_MAX = 8;
  localparam int IDX_W = $clog2(N_DIGITS_MAX);
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;
  function automatic logic [7:0] apply_pol(input logic [7:0] v, input logic active_low);
    return active_low ? ~v : v;
  endfunction
endpackage

// File: rtl/sseg_hex_decode.sv
// sseg_hex_decode: 4-bit hex to active-high 7-segment pattern (bit 0 = a).
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end
endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: N-digit 7-seg scan with frame-synced load, PWM and blink option SSEG_BLINK_EN.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int N_DIGITS = 6,
  parameter int SCAN_DIV = 65536,
  parameter int PWM_BITS = 3,
  parameter int AN_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
`ifdef SSEG_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef SSEG_BLINK_EN
  input  logic [N_DIGITS-1:0]     blink_in,
`endif
  input  logic [4*N_DIGITS-1:0]   digits_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  input  logic                    load_req,
  output logic                    load_ack,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_tick
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] PHASE_LEN = DIV_W'(SCAN_DIV >> PWM_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;
  logic [4*N_DIGITS-1:0] active_digits;
  logic [N_DIGITS-1:0] active_dp, active_blank, blank_eff;
  logic [PWM_BITS-1:0] phase;
  logic [3:0] hex_cur;
  logic [6:0] seg_cur;
  logic tick, frame_end, capture, lit, dp_cur, blank_cur;
  assign tick = div_cnt == DIV_LAST;
  assign frame_end = tick && idx == IDX_LAST;
  assign capture = frame_end && load_req;
  assign phase = PWM_BITS'(div_cnt / PHASE_LEN);
  assign lit = div_cnt != '0 && phase <= brightness;
  assign hex_cur = 4'(active_digits >> {idx, 2'b00});
  assign dp_cur = 1'(active_dp >> idx);
  assign blank_cur = 1'(blank_eff >> idx);
  sseg_hex_decode u_dec (.hex(hex_cur), .seg(seg_cur));
`ifdef SSEG_BLINK_EN
  localparam int FC_W = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
  logic [N_DIGITS-1:0] active_blink;
  logic [FC_W-1:0] frame_cnt;
  logic blink_phase;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_blink <= '0;
      frame_cnt <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (capture) active_blink <= blink_in;
      if (frame_end) frame_cnt <= frame_cnt == FC_LAST ? '0 : frame_cnt + 1'b1;
      if (frame_end && frame_cnt == FC_LAST) blink_phase <= ~blink_phase;
    end
  end
  assign blank_eff = active_blank | (active_blink & {N_DIGITS{blink_phase}});
`else
  assign blank_eff = active_blank;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx <= '0;
      active_digits <= '0;
      active_dp <= '0;
      active_blank <= '1;
      load_ack <= 1'b0;
      frame_tick <= 1'b0;
      an <= N_DIGITS'(apply_pol(8'h00, AN_ACTIVE_LOW != 0));
      {dp, sseg} <= apply_pol({1'b0, SEG_OFF}, SEG_ACTIVE_LOW != 0);
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= idx == IDX_LAST ? '0 : idx + 1'b1;
      frame_tick <= frame_end;
      load_ack <= capture;
      if (capture) begin
        active_digits <= digits_in;
        active_dp <= dp_in;
        active_blank <= blank_in;
      end
      an <= N_DIGITS'(apply_pol(8'(lit ? N_DIGITS'(1) << idx : N_DIGITS'(0)), AN_ACTIVE_LOW != 0));
      {dp, sseg} <= apply_pol(blank_cur ? {1'b0, SEG_OFF} : {dp_cur, seg_cur}, SEG_ACTIVE_LOW != 0);
    end
  end
endmodule
